// File: rtl/data_concat_pack.sv
// data_concat_pack: narrow-to-wide width up-converter.
// Gathers CONCAT_LEVEL beats of INPUT_DATA_WIDTH into one OUTPUT_DATA_WIDTH word.
// An accumulation register collects beats. A separate output register holds the
// finished word, so input keeps flowing while the output is stalled.
// last_in closes a word early for short tails.
// Optional build macro DATA_CONCAT_PACK_MSB_FIRST_EN places beat 0 in the MSB slice.
// Without it, beat 0 is placed in the LSB slice.
//
// Handshake: a beat transfers on fire_in = valid_in && ready_out, and a wide word
// transfers on fire_out = valid_out && ready_in. Once valid_out is high,
// data_out/last_out/beats_out hold steady until fire_out. Only a closing beat
// can be stalled, and only while the output register is full and not draining.
module data_concat_pack #(
    parameter int INPUT_DATA_WIDTH  = 256,
    parameter int OUTPUT_DATA_WIDTH = 1024,
    parameter int CONCAT_LEVEL      = OUTPUT_DATA_WIDTH / INPUT_DATA_WIDTH
) (
    input  logic                              clk,
    input  logic                              areset,
    input  logic                              ap_start,
    input  logic [INPUT_DATA_WIDTH-1:0]       data_in,
    input  logic                              valid_in,
    input  logic                              last_in,
    output logic                              ready_out,
    output logic [OUTPUT_DATA_WIDTH-1:0]      data_out,
    output logic                              valid_out,
    output logic                              last_out,
    output logic [$clog2(CONCAT_LEVEL):0]     beats_out,
    input  logic                              ready_in
);

    localparam int CNT_W = $clog2(CONCAT_LEVEL) + 1;
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(CONCAT_LEVEL - 1);

    logic [CNT_W-1:0]             fill_cnt;
    logic [OUTPUT_DATA_WIDTH-1:0] acc;
    logic [OUTPUT_DATA_WIDTH-1:0] merged;
    logic                         fire_in;
    logic                         fire_out;
    logic                         close_word;

    // A closing beat may enter only if the output register is free or draining now
    assign ready_out  = ((fill_cnt < LAST_SLOT) && !last_in) || !valid_out || ready_in;
    assign fire_in    = valid_in && ready_out;
    assign fire_out   = valid_out && ready_in;
    assign close_word = fire_in && ((fill_cnt == LAST_SLOT) || last_in);

    // Merge the incoming beat into the accumulator at the slot chosen by fill_cnt
    always_comb begin
        merged = acc;
        for (int k = 0; k < CONCAT_LEVEL; k++) begin
            if (fill_cnt == CNT_W'(k)) begin
`ifdef DATA_CONCAT_PACK_MSB_FIRST_EN
                merged[(CONCAT_LEVEL-1-k)*INPUT_DATA_WIDTH +: INPUT_DATA_WIDTH] = data_in;
`else
                merged[k*INPUT_DATA_WIDTH +: INPUT_DATA_WIDTH] = data_in;
`endif
            end
        end
    end

    // Accumulator, fill counter and output register. ap_start acts as a clear and
    // overrides any transfer in the same cycle.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            fill_cnt  <= '0;
            acc       <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            last_out  <= 1'b0;
            beats_out <= '0;
        end else if (ap_start) begin
            fill_cnt  <= '0;
            acc       <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            last_out  <= 1'b0;
            beats_out <= '0;
        end else if (close_word) begin
            // A close wins over a drain, so back-to-back words leave no bubble
            data_out  <= merged;
            valid_out <= 1'b1;
            last_out  <= last_in;
            beats_out <= fill_cnt + CNT_W'(1);
            fill_cnt  <= '0;
            acc       <= '0;
        end else begin
            if (fire_in) begin
                acc      <= merged;
                fill_cnt <= fill_cnt + CNT_W'(1);
            end
            if (fire_out) begin
                valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_data_concat_pack.sv
// Directed bench for data_concat_pack built as 32-bit beats into 128-bit words
// (four beats per word). Expected words are built here by hand from the beats.
module tb_data_concat_pack;

    localparam int IN  = 32;
    localparam int OUT = 128;
    localparam int CL  = 4;

    logic            clk;
    logic            areset;
    logic            ap_start;
    logic [IN-1:0]   data_in;
    logic            valid_in;
    logic            last_in;
    logic            ready_out;
    logic [OUT-1:0]  data_out;
    logic            valid_out;
    logic            last_out;
    logic [2:0]      beats_out;
    logic            ready_in;

    int checks = 0;
    int errors = 0;

    data_concat_pack #(
        .INPUT_DATA_WIDTH (IN),
        .OUTPUT_DATA_WIDTH(OUT),
        .CONCAT_LEVEL     (CL)
    ) dut (
        .clk      (clk),
        .areset   (areset),
        .ap_start (ap_start),
        .data_in  (data_in),
        .valid_in (valid_in),
        .last_in  (last_in),
        .ready_out(ready_out),
        .data_out (data_out),
        .valid_out(valid_out),
        .last_out (last_out),
        .beats_out(beats_out),
        .ready_in (ready_in)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // comparison point
    task automatic check(input string tag, input logic [OUT-1:0] got, input logic [OUT-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [IN-1:0] bt(input logic [7:0] b);
        return {4{b}};
    endfunction

    // Word from beats in arrival order; unused beats passed as zero
    function automatic logic [OUT-1:0] pack(input logic [IN-1:0] b0, input logic [IN-1:0] b1,
                                            input logic [IN-1:0] b2, input logic [IN-1:0] b3);
`ifdef DATA_CONCAT_PACK_MSB_FIRST_EN
        return {b0, b1, b2, b3};
`else
        return {b3, b2, b1, b0};
`endif
    endfunction

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [IN-1:0] d, input logic l);
        valid_in = 1'b1;
        data_in  = d;
        last_in  = l;
        #1;
    endtask

    task automatic idle();
        valid_in = 1'b0;
        last_in  = 1'b0;
        data_in  = '0;
        #1;
    endtask

    task automatic check_word(input string tag, input logic [OUT-1:0] exp, input int nb, input logic lst);
        check({tag, "_valid"}, OUT'(valid_out), OUT'(1'b1));
        check({tag, "_data"},  data_out, exp);
        check({tag, "_beats"}, OUT'(beats_out), OUT'(nb));
        check({tag, "_last"},  OUT'(last_out), OUT'(lst));
    endtask

    logic [OUT-1:0] word_a;
    logic [OUT-1:0] word_b;

    initial begin
        areset = 1'b1;
        ap_start = 1'b0;
        valid_in = 1'b0;
        last_in  = 1'b0;
        data_in  = '0;
        ready_in = 1'b1;
        #12;
        check("rst_valid", OUT'(valid_out), '0);
        check("rst_data",  data_out, '0);
        check("rst_beats", OUT'(beats_out), '0);
        check("rst_last",  OUT'(last_out), '0);
        @(negedge clk);
        areset = 1'b0;
        tick();

        // full word A1..A4
        word_a = pack(bt(8'hA1), bt(8'hA2), bt(8'hA3), bt(8'hA4));
        for (int i = 0; i < 4; i++) begin
            present(bt(8'(8'hA1 + i)), 1'b0);
            check("full_ready", OUT'(ready_out), OUT'(1'b1));
            tick();
            if (i < 3) check("full_nvalid", OUT'(valid_out), '0);
        end
        check_word("full", word_a, 4, 1'b0);

        // back-pressure: A pending, B1..B3 accepted, B4 stalled
        ready_in = 1'b0;
        word_b = pack(bt(8'hB1), bt(8'hB2), bt(8'hB3), bt(8'hB4));
        for (int i = 0; i < 3; i++) begin
            present(bt(8'(8'hB1 + i)), 1'b0);
            check("bp_ready", OUT'(ready_out), OUT'(1'b1));
            tick();
        end
        present(bt(8'hB4), 1'b0);
        check("bp_stall", OUT'(ready_out), '0);
        tick();
        check_word("bp_hold", word_a, 4, 1'b0);
        ready_in = 1'b1;
        #1;
        check("bp_release", OUT'(ready_out), OUT'(1'b1));
        tick();
        check_word("bp_b", word_b, 4, 1'b0);

        // partial close C1, C2(last), then single-beat D1(last)
        present(bt(8'hC1), 1'b0);
        tick();
        check("part_drain", OUT'(valid_out), '0);
        present(bt(8'hC2), 1'b1);
        check("part_ready", OUT'(ready_out), OUT'(1'b1));
        tick();
        check_word("part_c", pack(bt(8'hC1), bt(8'hC2), '0, '0), 2, 1'b1);
        present(bt(8'hD1), 1'b1);
        tick();
        check_word("single_d", pack(bt(8'hD1), '0, '0, '0), 1, 1'b1);
        idle();
        tick();

        // streaming eight beats E1..E8
        for (int i = 0; i < 8; i++) begin
            present(bt(8'(8'hE1 + i)), 1'b0);
            check("stream_ready", OUT'(ready_out), OUT'(1'b1));
            tick();
            if (i == 3) check_word("stream_w1", pack(bt(8'hE1), bt(8'hE2), bt(8'hE3), bt(8'hE4)), 4, 1'b0);
            else if (i == 7) check_word("stream_w2", pack(bt(8'hE5), bt(8'hE6), bt(8'hE7), bt(8'hE8)), 4, 1'b0);
            else check("stream_gap", OUT'(valid_out), '0);
        end
        idle();
        tick();

        // ap_start after 3 beats, overriding a would-be closing beat
        for (int i = 0; i < 3; i++) begin
            present(bt(8'(8'hF1 + i)), 1'b0);
            tick();
        end
        present(bt(8'hF4), 1'b0);
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        check("aps_valid", OUT'(valid_out), '0);
        check("aps_data",  data_out, '0);
        for (int i = 0; i < 4; i++) begin
            present(bt(8'(8'h61 + i)), 1'b0);
            tick();
            if (i < 3) check("aps_nvalid", OUT'(valid_out), '0);
        end
        check_word("aps_g", pack(bt(8'h61), bt(8'h62), bt(8'h63), bt(8'h64)), 4, 1'b0);

        // areset between edges with a word pending
        ready_in = 1'b0;
        idle();
        #2;
        areset = 1'b1;
        #1;
        check("arst_valid", OUT'(valid_out), '0);
        check("arst_data",  data_out, '0);
        check("arst_beats", OUT'(beats_out), '0);
        @(negedge clk);
        areset = 1'b0;
        ready_in = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            present(bt(8'(8'h71 + i)), 1'b0);
            tick();
        end
        check_word("arst_after", pack(bt(8'h71), bt(8'h72), bt(8'h73), bt(8'h74)), 4, 1'b0);
        idle();
        tick();

        // final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
